// File: rtl/mips_cpu_regfile_alu_if.sv
// rtl/mips_cpu_regfile_alu_if.sv - register file and ALU signal bundle
// Purpose: groups the register-file read/write ports and ALU ports.
//   master: CPU side (drives indices, write-back, op/operands)
//   slave : datapath side (returns read data, register_v0, result, zero)
interface mips_cpu_regfile_alu_if;
    logic        write;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [4:0]  rdAddrA;
    logic [31:0] rdDataA;
    logic [4:0]  rdAddrB;
    logic [31:0] rdDataB;
    logic [31:0] register_v0;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] result;
    logic        zero;

    modport master (
        output write, wrAddr, wrData, rdAddrA, rdAddrB, op, a, b, sa,
        input  rdDataA, rdDataB, register_v0, result, zero
    );

    modport slave (
        input  write, wrAddr, wrData, rdAddrA, rdAddrB, op, a, b, sa,
        output rdDataA, rdDataB, register_v0, result, zero
    );
endinterface

// File: rtl/mips_cpu_regfile_alu.sv
// rtl/mips_cpu_regfile_alu.sv - MIPS32 register file plus combinational ALU
// Purpose: 32x32 register file (r0 hardwired to zero, two combinational
//   read ports, one write port) and a 32-bit integer ALU.
// Ports:
//   clk   - rising-edge clock for register writes
//   reset - asynchronous active-high, clears all registers
//   bus   - slave side of mips_cpu_regfile_alu_if (read/write ports,
//           register_v0, op/a/b/sa, result/zero)
module mips_cpu_regfile_alu (
    input logic                     clk,
    input logic                     reset,
    mips_cpu_regfile_alu_if.slave   bus
);
    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_OR   = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SLL  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_SLLV = 5'd9;
    localparam logic [4:0] OP_SRLV = 5'd10;
    localparam logic [4:0] OP_SRAV = 5'd11;

    logic [31:0] regs [32];

    // Register 0 is never written, so it only ever holds its reset value;
    // reads of index 0 are also forced to zero below for safety.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.write && (bus.wrAddr != 5'd0)) begin
            regs[bus.wrAddr] <= bus.wrData;
        end
    end

    // No write bypass: a same-index read sees the old value until the edge.
    assign bus.rdDataA     = (bus.rdAddrA == 5'd0) ? 32'h0 : regs[bus.rdAddrA];
    assign bus.rdDataB     = (bus.rdAddrB == 5'd0) ? 32'h0 : regs[bus.rdAddrB];
    assign bus.register_v0 = regs[2];

    // Variable shifts take their amount from a[4:0]; immediate shifts from sa.
    logic [4:0]  shamt;
    logic        var_shift;
    logic [31:0] alu_res;

    assign var_shift = (bus.op == OP_SLLV) || (bus.op == OP_SRLV) || (bus.op == OP_SRAV);
    assign shamt     = var_shift ? bus.a[4:0] : bus.sa;

    always_comb begin
        alu_res = 32'h0;
        case (bus.op)
            OP_AND:           alu_res = bus.a & bus.b;
            OP_OR:            alu_res = bus.a | bus.b;
            OP_ADD:           alu_res = bus.a + bus.b;
            OP_SUB:           alu_res = bus.a - bus.b;
            OP_SLT:           alu_res = {31'h0, ($signed(bus.a) < $signed(bus.b))};
            OP_XOR:           alu_res = bus.a ^ bus.b;
            OP_SLL, OP_SLLV:  alu_res = bus.b << shamt;
            OP_SRL, OP_SRLV:  alu_res = bus.b >> shamt;
            OP_SRA, OP_SRAV:  alu_res = $unsigned($signed(bus.b) >>> shamt);
            default:          alu_res = 32'h0;
        endcase
    end

    assign bus.result = alu_res;
    assign bus.zero   = (alu_res == 32'h0);
endmodule

// File: tb/tb_mips_cpu_regfile_alu.sv
// tb/tb_mips_cpu_regfile_alu.sv - self-checking bench for mips_cpu_regfile_alu
module tb_mips_cpu_regfile_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;

    mips_cpu_regfile_alu_if bus ();

    mips_cpu_regfile_alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    // Reference register state: plain array, index 0 never updated.
    logic [31:0] model_regs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Reference ALU built from arithmetic definitions rather than operators
    // on bit vectors where possible.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sa);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint m  = 64'h1_0000_0000;
        longint sb = (b[31]) ? ub - m : ub;
        longint sgn_a = (a[31]) ? ua - m : ua;
        int sh = (op >= 5'd9) ? int'(a[4:0]) : int'(sa);
        longint p = longint'(1) << sh;
        longint r;
        case (op)
            5'd0: return a & b;
            5'd1: return a | b;
            5'd2: begin r = (ua + ub) % m; return r[31:0]; end
            5'd3: begin r = (ua + m - ub) % m; return r[31:0]; end
            5'd4: return (sgn_a < sb) ? 32'd1 : 32'd0;
            5'd5: return a ^ b;
            5'd6, 5'd9:  begin r = (ub * p) % m; return r[31:0]; end
            5'd7, 5'd10: begin r = ub / p; return r[31:0]; end
            5'd8, 5'd11: begin
                if (sb >= 0) r = sb / p;
                else r = -(((-sb) + p - 1) / p);
                r = (r + m) % m;
                return r[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge reset) begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (!reset && bus.write && bus.wrAddr != 5'd0)
            model_regs[bus.wrAddr] = bus.wrData;
    end

    // Continuous compare on the falling edge, away from the write edge.
    always @(negedge clk) begin
        logic [31:0] er;
        if (chk_en) begin
            er = ref_alu(bus.op, bus.a, bus.b, bus.sa);
            chk("cyc_rdDataA", bus.rdDataA, model_regs[bus.rdAddrA]);
            chk("cyc_rdDataB", bus.rdDataB, model_regs[bus.rdAddrB]);
            chk("cyc_v0", bus.register_v0, model_regs[2]);
            chk("cyc_result", bus.result, er);
            chk("cyc_zero", {31'h0, bus.zero}, {31'h0, (er == 32'h0)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_chk(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sa,
                           input logic [31:0] exp_r, input logic exp_z);
        bus.op = op; bus.a = a; bus.b = b; bus.sa = sa;
        #1;
        chk(name, bus.result, exp_r);
        chk({name, "_zero"}, {31'h0, bus.zero}, {31'h0, exp_z});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        bus.write = 0; bus.wrAddr = 0; bus.wrData = 0;
        bus.rdAddrA = 0; bus.rdAddrB = 0;
        bus.op = 0; bus.a = 0; bus.b = 0; bus.sa = 0;
        repeat (3) step();
        reset = 0;
        chk_en = 1'b1;

        // Reset state
        bus.rdAddrA = 2; bus.rdAddrB = 31; #1;
        chk("reset_rdA", bus.rdDataA, 32'h0);
        chk("reset_rdB", bus.rdDataB, 32'h0);
        chk("reset_v0", bus.register_v0, 32'h0);

        // Write r2 with same-cycle read of old value
        step();
        bus.write = 1; bus.wrAddr = 2; bus.wrData = 32'h12345678; bus.rdAddrA = 2;
        #2;
        chk("rdw_old", bus.rdDataA, 32'h0);
        step();
        chk("rdw_new", bus.rdDataA, 32'h12345678);
        chk("v0_after_write", bus.register_v0, 32'h12345678);
        bus.wrAddr = 31; bus.wrData = 32'hFFFFFFFF;
        step();
        bus.write = 0; bus.rdAddrA = 2; bus.rdAddrB = 31; #1;
        chk("read_r2", bus.rdDataA, 32'h12345678);
        chk("read_r31", bus.rdDataB, 32'hFFFFFFFF);

        // write=0 leaves state unchanged
        bus.wrAddr = 2; bus.wrData = 32'hAAAA5555;
        step();
        chk("nowrite_r2", bus.rdDataA, 32'h12345678);

        // r0 hardwired
        bus.write = 1; bus.wrAddr = 0; bus.wrData = 32'hDEADBEEF;
        step();
        bus.write = 0; bus.rdAddrA = 0; bus.rdAddrB = 0; #1;
        chk("r0_A", bus.rdDataA, 32'h0);
        chk("r0_B", bus.rdDataB, 32'h0);

        // ALU directed values
        alu_chk("add_wrap", 5'd2, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1);
        alu_chk("sub_neg", 5'd3, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0);
        alu_chk("and", 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0);
        alu_chk("or", 5'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0);
        alu_chk("xor", 5'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00, 1'b0);
        alu_chk("slt_neg", 5'd4, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0);
        alu_chk("slt_pos", 5'd4, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1);
        alu_chk("sll", 5'd6, 32'h0, 32'h80000001, 5'd4, 32'h00000010, 1'b0);
        alu_chk("srl", 5'd7, 32'h0, 32'h80000001, 5'd4, 32'h08000000, 1'b0);
        alu_chk("sra", 5'd8, 32'h0, 32'h80000001, 5'd4, 32'hF8000000, 1'b0);
        alu_chk("srav", 5'd11, 32'hFFFFFFE4, 32'h80000001, 5'd0, 32'hF8000000, 1'b0);
        alu_chk("srlv", 5'd10, 32'hFFFFFFE4, 32'h80000001, 5'd0, 32'h08000000, 1'b0);
        alu_chk("sll_sa0", 5'd6, 32'h0, 32'h80000001, 5'd0, 32'h80000001, 1'b0);
        alu_chk("sra_sa0", 5'd8, 32'h0, 32'h80000001, 5'd0, 32'h80000001, 1'b0);
        alu_chk("undef_op", 5'd20, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h0, 1'b1);

        // Randomized traffic checked every cycle by the compare process
        for (int n = 0; n < 300; n++) begin
            step();
            bus.write   = 1'($urandom);
            bus.wrAddr  = 5'($urandom);
            bus.wrData  = $urandom;
            bus.rdAddrA = 5'($urandom);
            bus.rdAddrB = (n % 7 == 0) ? bus.rdAddrA : 5'($urandom);
            bus.op      = 5'($urandom_range(0, 13));
            bus.a       = $urandom;
            bus.b       = (n % 11 == 0) ? bus.a : $urandom;
            bus.sa      = 5'($urandom);
        end

        // Asynchronous reset pulsed mid-cycle clears everything
        step();
        bus.write = 0;
        #2;
        reset = 1;
        #1;
        chk("async_v0", bus.register_v0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.rdAddrA = 5'(i); bus.rdAddrB = 5'(31 - i);
            #1;
            chk("async_rdA", bus.rdDataA, 32'h0);
            chk("async_rdB", bus.rdDataB, 32'h0);
        end

        // Write attempted while reset is held
        step();
        bus.write = 1; bus.wrAddr = 5; bus.wrData = 32'hCAFEF00D;
        step();
        step();
        reset = 0; bus.write = 0; bus.rdAddrA = 5; #1;
        chk("reset_blocks_write", bus.rdDataA, 32'h0);

        // More random traffic after reset
        for (int n = 0; n < 100; n++) begin
            step();
            bus.write   = 1'($urandom);
            bus.wrAddr  = 5'($urandom);
            bus.wrData  = $urandom;
            bus.rdAddrA = 5'($urandom);
            bus.rdAddrB = 5'($urandom);
            bus.op      = 5'($urandom);
            bus.a       = $urandom;
            bus.b       = $urandom;
            bus.sa      = 5'($urandom);
        end
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_cpu_regfile_alu.md
Name: mips_cpu_regfile_alu

Overview:
- Combined MIPS32 datapath core: a 32x32-bit general-purpose register file plus a combinational integer ALU.
- Instantiated by the multicycle bus CPU.
- The register file supplies operands A/B and accepts write-back.
- The ALU computes arithmetic, logic and shift results from operands latched by the CPU.
- Register $2 ($v0) is exported for test observation.

Parameters:
- none (datapath fixed at 32 bits, 32 registers, 5-bit op code)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all registers
- write  input  1  register write enable, sampled on rising clk
- wrAddr  input  5  destination register index
- wrData  input  32  write-back data
- rdAddrA  input  5  read port A index
- rdDataA  output  32  read port A data (combinational)
- rdAddrB  input  5  read port B index
- rdDataB  output  32  read port B data (combinational)
- register_v0  output  32  continuous copy of register 2
- op  input  5  ALU operation select
- a  input  32  ALU operand A
- b  input  32  ALU operand B
- sa  input  5  immediate shift amount (instr[10:6])
- result  output  32  ALU result (combinational)
- zero  output  1  high when result == 0

Behaviour:
Register file:
- reset=1 asynchronously forces all 32 registers to 0, independent of clk.
- While reset is high, writes are ignored.
- After reset: rdDataA = rdDataB = register_v0 = 0.
- Write: on rising clk with write=1 and reset=0, reg[wrAddr] <= wrData. Latency 1 clock; no other state.
- Register 0 is hardwired to zero: writes to index 0 are discarded, and reads of index 0 always return 0.
- Reads are purely combinational from the array. Both ports may address the same register, returning identical data.
- Read-during-write to the same index returns the old value until the edge, then the new value (no bypass).
- register_v0 always reflects reg[2] and updates on the same edge as a write to index 2.

ALU:
- Purely combinational; no clock.
- 0 AND: a & b
- 1 OR: a | b
- 2 ADD: a + b modulo 2^32; no overflow trap or flag
- 3 SUB: a - b modulo 2^32; no trap
- 4 SLT: signed(a) < signed(b) ? 1 : 0, zero-extended to 32 bits
- 5 XOR: a ^ b
- 6 SLL: b << sa
- 7 SRL: b >> sa, logical (zero fill)
- 8 SRA: b >>> sa, arithmetic (sign fill from b[31])
- 9 SLLV: b << a[4:0]
- 10 SRLV: b >> a[4:0], logical
- 11 SRAV: b >>> a[4:0], arithmetic
- 12-31: result = 0, so zero = 1
- Shift amounts use only 5 bits; a[31:5] is ignored for variable shifts. A shift of 0 returns b unchanged.
- zero = (result == 32'h0) for every op.
- ALU outputs are unaffected by reset.

Test Plan:
- Reset/hardwired zero: pulse reset mid-cycle (asynchronous); read all indices -> 0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write/read: write r2=0x12345678 and r31=0xFFFFFFFF. Next cycle, rdAddrA=2/rdAddrB=31 -> 0x12345678 and 0xFFFFFFFF; register_v0 = 0x12345678. Same-cycle read of r2 before the edge returns the old value 0. Write with write=0 -> no change.
- Arithmetic wrap/zero: ADD 0xFFFFFFFF+1 -> 0, zero=1. SUB 5-7 -> 0xFFFFFFFE, zero=0.
- Logic/SLT: AND/OR/XOR of 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00. SLT(0xFFFFFFFF, 1) -> 1; SLT(1, 0xFFFFFFFF) -> 0.
- Shifts: b=0x80000001, sa=4. SLL -> 0x00000010, SRL -> 0x08000000, SRA -> 0xF8000000. SRAV with a=0xFFFFFFE4 (shift 4) -> 0xF8000000. sa=0 -> 0x80000001.
- Reset during write: reset high with write=1, wrAddr=5 -> r5 stays 0. Undefined op 20 -> result 0, zero=1.
